// File: rtl/fetch_unit.sv
// Instruction fetch stage: pulls words from instruction memory at pc and hands them to decode.
// Latency: ir_valid rises one cycle after mem_ack; optional FETCH_PREFETCH_EN adds a one-entry prefetch buffer.
// Backpressure: ir is held while ir_ready=0; fetching stalls until ir (and pbuf, if present) has room.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [15:0] pc_d,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_addr
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    logic [0:0] state;
    logic       xfer;
    logic       mem_fire;

    assign xfer     = ir_valid & ir_ready;
    assign pc_d     = redirect_addr;
    assign pc_load  = ~rst & redirect;
    assign mem_addr = pc;
    assign ir_valid = (state == S_VALID);
    assign mem_fire = mem_req & mem_ack;
    // pc only advances for a word actually captured; redirect suppresses mem_req, so pc_inc too.
    assign pc_inc   = mem_fire;

`ifdef FETCH_PREFETCH_EN
    logic [15:0] pbuf;
    logic [15:0] pbuf_pc;
    logic        pbuf_valid;

    assign mem_req = ~rst & ~redirect & ((state == S_FETCH) | ~pbuf_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            ir         <= 16'h0000;
            ir_pc      <= 16'h0000;
            pbuf       <= 16'h0000;
            pbuf_pc    <= 16'h0000;
            pbuf_valid <= 1'b0;
        end else if (redirect) begin
            state      <= S_FETCH;
            pbuf_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_fire) begin
                        ir    <= mem_rdata;
                        ir_pc <= pc;
                        state <= S_VALID;
                    end
                end
                default: begin
                    // A full pbuf blocks mem_req, so mem_fire and pbuf_valid never coincide here.
                    if (xfer) begin
                        if (pbuf_valid) begin
                            ir         <= pbuf;
                            ir_pc      <= pbuf_pc;
                            pbuf_valid <= 1'b0;
                        end else if (mem_fire) begin
                            ir    <= mem_rdata;
                            ir_pc <= pc;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (mem_fire) begin
                        pbuf       <= mem_rdata;
                        pbuf_pc    <= pc;
                        pbuf_valid <= 1'b1;
                    end
                end
            endcase
        end
    end
`else
    assign mem_req = ~rst & ~redirect & (state == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= 16'h0000;
            ir_pc <= 16'h0000;
        end else if (redirect) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_fire) begin
                        ir    <= mem_rdata;
                        ir_pc <= pc;
                        state <= S_VALID;
                    end
                end
                default: begin
                    if (xfer) state <= S_FETCH;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, scored against an in-order
// instruction-stream model (decode must see mem[a], mem[a+1], ... restarting at each redirect).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = 16'h0000;
    logic        pc_inc, pc_load;
    logic [15:0] pc_d;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] ir, ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;

    logic        pc_force = 1'b0;
    logic [15:0] pc_force_val = 16'h0000;

`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 2;
    localparam int PF  = 1;
`else
    localparam int CAP = 1;
    localparam int PF  = 0;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_inc(pc_inc), .pc_load(pc_load), .pc_d(pc_d),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect(redirect), .redirect_addr(redirect_addr)
    );

    // Program counter owned by the environment.
    always @(posedge clk) begin
        if (pc_force)     pc <= pc_force_val;
        else if (pc_load) pc <= pc_d;
        else if (pc_inc)  pc <= pc + 16'd1;
    end

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0;
    int n_inc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    logic [15:0] exp_addr = 16'h0000;
    bit          prev_rst = 1'b0;
    bit          p_hold = 1'b0, p_wait = 1'b0, p_fill = 1'b0, p_redir = 1'b0;
    logic [15:0] p_ir = 16'h0000, p_irpc = 16'h0000, p_addr = 16'h0000;

    task automatic check_cycle();
        logic [15:0] outst;
        bit          exp_req;
        chk("pc_d", 32'(pc_d), 32'(redirect_addr));
        chk("inc_and_load", 32'(pc_inc & pc_load), 0);
        if (prev_rst) begin
            chk("rst_ir_valid", 32'(ir_valid), 0);
            chk("rst_ir", 32'(ir), 0);
            chk("rst_ir_pc", 32'(ir_pc), 0);
        end
        if (rst) begin
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_pc_inc", 32'(pc_inc), 0);
            chk("rst_pc_load", 32'(pc_load), 0);
            exp_addr = pc_force ? pc_force_val : pc;
            {p_hold, p_wait, p_fill, p_redir} = 4'b0000;
            prev_rst = 1'b1;
        end else begin
            // Words fetched (pc advanced) but not yet delivered to decode.
            outst = pc - exp_addr;
            if (PF == 0)
                chk("outstanding", 32'(outst), 32'(ir_valid));
            else
                chk("outstanding_pf", 32'(32'(outst) <= 2 && 32'(outst) >= 32'(ir_valid)
                                          && (ir_valid || outst == 16'd0)), 1);
            exp_req = !redirect && (32'(outst) < CAP);
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(pc));
            chk("pc_inc", 32'(pc_inc), 32'(exp_req && mem_ack));
            chk("pc_load", 32'(pc_load), 32'(redirect));
            if (p_hold) begin
                chk("hold_valid", 32'(ir_valid), 1);
                chk("hold_ir", 32'(ir), 32'(p_ir));
                chk("hold_ir_pc", 32'(ir_pc), 32'(p_irpc));
            end
            if (p_wait && !redirect) chk("wait_addr", 32'(mem_addr), 32'(p_addr));
            if (p_fill) begin
                chk("fill_valid", 32'(ir_valid), 1);
                chk("fill_ir", 32'(ir), 32'(mem_word(p_addr)));
                chk("fill_ir_pc", 32'(ir_pc), 32'(p_addr));
            end
            if (p_redir) chk("redir_flush", 32'(ir_valid), 0);
            if (ir_valid && ir_ready && !redirect) begin
                chk("xfer_ir_pc", 32'(ir_pc), 32'(exp_addr));
                chk("xfer_ir", 32'(ir), 32'(mem_word(exp_addr)));
                exp_addr = exp_addr + 16'd1;
                n_xfer++;
            end
            if (redirect) exp_addr = redirect_addr;
            if (pc_inc) n_inc++;
            p_hold  = ir_valid && !ir_ready && !redirect;
            p_wait  = exp_req && !mem_ack;
            p_fill  = exp_req && mem_ack && !ir_valid;
            p_redir = redirect;
            p_addr  = pc;
            p_ir    = ir;
            p_irpc  = ir_pc;
            prev_rst = 1'b0;
        end
    endtask

    task automatic cycle(input logic r, input logic rd, input logic ack, input logic redir,
                         input logic [15:0] raddr, input logic fp, input logic [15:0] fv);
        @(negedge clk);
        rst           = r;
        ir_ready      = rd;
        mem_ack       = ack;
        redirect      = redir;
        redirect_addr = raddr;
        pc_force      = fp;
        pc_force_val  = fv;
        mem_rdata     = ack ? mem_word(pc) : 16'($urandom);
        #1;
        check_cycle();
    endtask

    initial begin
        // Reset release and first fetch.
        cycle(1, 0, 0, 0, 16'h0000, 1, 16'h0010);
        cycle(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        cycle(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        chk("first_addr", 32'(mem_addr), 32'h0010);
        chk("first_inc", 32'(pc_inc), 1);
        cycle(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("first_ir", 32'(ir), 32'hA5A5);
        chk("first_ir_pc", 32'(ir_pc), 32'h0010);
        chk("first_valid", 32'(ir_valid), 1);
        chk("first_inc_pulse", 32'(pc_inc), 0);

        // Decode stalled for 5 cycles.
        n_inc = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
            chk("stall_ir", 32'(ir), 32'hA5A5);
            chk("stall_valid", 32'(ir_valid), 1);
        end
        chk("stall_inc_count", 32'(n_inc), 32'(PF));

        // Slow memory: ack arrives after 3 wait cycles.
        cycle(0, 0, 0, 1, 16'h0300, 0, 16'h0000);
        n_inc = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
            chk("wait_req", 32'(mem_req), 1);
            chk("wait_addr0300", 32'(mem_addr), 32'h0300);
        end
        cycle(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        chk("wait_ack_inc", 32'(pc_inc), 1);
        chk("wait_inc_count", 32'(n_inc), 1);
        cycle(0, 1, 0, 0, 16'h0000, 0, 16'h0000);

        // Redirect coincident with an ack.
        cycle(0, 0, 1, 1, 16'h0200, 0, 16'h0000);
        chk("redir_load", 32'(pc_load), 1);
        chk("redir_pc_d", 32'(pc_d), 32'h0200);
        chk("redir_inc", 32'(pc_inc), 0);
        chk("redir_req", 32'(mem_req), 0);
        cycle(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("redir_valid", 32'(ir_valid), 0);
        chk("redir_refetch", 32'(mem_addr), 32'h0200);

        // Fill every slot, then reset with redirect and ack pending.
        cycle(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        cycle(0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        cycle(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
        chk("full_no_req", 32'(mem_req), 0);
        cycle(1, 0, 1, 1, 16'h0700, 1, 16'h0400);
        chk("rst_over_redir", 32'(pc_load), 0);
        cycle(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        cycle(0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        chk("post_rst_addr", 32'(mem_addr), 32'h0400);
        cycle(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
        chk("post_rst_ir_pc", 32'(ir_pc), 32'h0400);

        // Zero-wait memory, decode always ready, from pc=0.
        cycle(1, 0, 0, 0, 16'h0000, 1, 16'h0000);
        cycle(1, 0, 0, 0, 16'h0000, 0, 16'h0000);
        n_xfer = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, 1, 0, 16'h0000, 0, 16'h0000);
            if (PF != 0) begin
                if (k >= 1) chk("stream_ir_pc", 32'(ir_pc), 32'(k - 1));
            end else begin
                chk("stream_valid", 32'(ir_valid), 32'(k % 2));
            end
        end
        chk("stream_count", 32'(n_xfer), (PF != 0) ? 7 : 4);

        // Random traffic, with redirects near the top of the address space.
        cycle(1, 0, 0, 0, 16'h0000, 1, 16'($urandom));
        for (int i = 0; i < 3000; i++) begin
            logic r, rd, ack, rdir;
            logic [15:0] ra;
            r    = ($urandom_range(0, 199) == 0);
            rd   = ($urandom_range(0, 9) < 7);
            ack  = ($urandom_range(0, 9) < 6);
            rdir = ($urandom_range(0, 29) == 0);
            ra   = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            cycle(r, rd, ack, rdir, ra, r, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
